// File: rtl/slot_ring_table.sv
// slot_ring_table
//   A ring of DEPTH = 2^INDEX_WIDTH descriptor slots. Each slot moves through
//   EMPTY -> PENDING -> BUSY -> DONE -> EMPTY. Four ring pointers track the
//   next slot to allocate, dispatch, complete and free. While a slot is BUSY,
//   its profile counter measures its busy time in cycles.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   wr_valid/ready    allocate handshake; wr_src_*/wr_des_* is the descriptor
//   disp_valid/ready  dispatch handshake for the oldest PENDING slot;
//                     disp_index/disp_src_*/disp_des_* is that slot
//   cmpl              completion pulse for the oldest BUSY slot
//   free              release pulse for the oldest DONE slot
//   rd_index          combinational read port; returns the fields,
//                     status and profile of slot rd_index on rd_*
//   occupancy         number of non-EMPTY slots
//   err               one-cycle pulse after an illegal cmpl or free
module slot_ring_table #(
  parameter int INDEX_WIDTH    = 2,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int PROFILE_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SRC_ADDR_WIDTH-1:0] wr_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0] wr_src_size,
  input  logic [DST_ADDR_WIDTH-1:0] wr_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0] wr_des_size,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [INDEX_WIDTH-1:0]    disp_index,
  output logic [SRC_ADDR_WIDTH-1:0] disp_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] disp_src_size,
  output logic [DST_ADDR_WIDTH-1:0] disp_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] disp_des_size,
  input  logic                      cmpl,
  input  logic                      free,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  output logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
  output logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] rd_des_size,
  output logic [1:0]                rd_status,
  output logic [PROFILE_WIDTH-1:0]  rd_profile,
  output logic [INDEX_WIDTH:0]      occupancy,
  output logic                      err
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] FULL_COUNT = (INDEX_WIDTH+1)'(DEPTH);
  localparam logic [PROFILE_WIDTH-1:0] PROFILE_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } slotStatus_e;

  slotStatus_e                status_q   [DEPTH];
  logic [SRC_ADDR_WIDTH-1:0]  srcAddr_q  [DEPTH];
  logic [SRC_SIZE_WIDTH-1:0]  srcSize_q  [DEPTH];
  logic [DST_ADDR_WIDTH-1:0]  desAddr_q  [DEPTH];
  logic [DST_SIZE_WIDTH-1:0]  desSize_q  [DEPTH];
  logic [PROFILE_WIDTH-1:0]   profile_q  [DEPTH];

  logic [INDEX_WIDTH-1:0] allocPtr_q, allocPtr_d;
  logic [INDEX_WIDTH-1:0] dispPtr_q, dispPtr_d;
  logic [INDEX_WIDTH-1:0] cmplPtr_q, cmplPtr_d;
  logic [INDEX_WIDTH-1:0] freePtr_q, freePtr_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;
  logic                   err_q, err_d;

  logic doAlloc, doDisp, doCmpl, doFree;
  logic cmplOk, freeOk;

  // Work out which operations are legal this cycle from registered state only.
  // The four accepted operations always target different slots: the alloc
  // slot is EMPTY, the free slot is DONE, and the cmpl slot must already be
  // BUSY at the start of the cycle. A slot that is dispatched this cycle is
  // therefore never completed in the same cycle.
  always_comb begin
    wr_ready   = (count_q < FULL_COUNT);
    disp_valid = (status_q[dispPtr_q] == PENDING);
    cmplOk     = (status_q[cmplPtr_q] == BUSY);
    freeOk     = (status_q[freePtr_q] == DONE);
    doAlloc    = wr_valid && wr_ready;
    doDisp     = disp_valid && disp_ready;
    doCmpl     = cmpl && cmplOk;
    doFree     = free && freeOk;
  end

  // Advance the pointers and occupancy. Flag any illegal cmpl or free.
  always_comb begin
    allocPtr_d = allocPtr_q;
    dispPtr_d  = dispPtr_q;
    cmplPtr_d  = cmplPtr_q;
    freePtr_d  = freePtr_q;
    if (doAlloc) allocPtr_d = allocPtr_q + INDEX_WIDTH'(1);
    if (doDisp)  dispPtr_d  = dispPtr_q + INDEX_WIDTH'(1);
    if (doCmpl)  cmplPtr_d  = cmplPtr_q + INDEX_WIDTH'(1);
    if (doFree)  freePtr_d  = freePtr_q + INDEX_WIDTH'(1);
    count_d = count_q + (INDEX_WIDTH+1)'(doAlloc) - (INDEX_WIDTH+1)'(doFree);
    err_d   = (cmpl && !cmplOk) || (free && !freeOk);
  end

  // Update the slot storage and control registers. A BUSY slot's profile
  // counts on every edge where the slot is BUSY at the start of the cycle.
  // This includes the completion edge, but not the dispatch edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      allocPtr_q <= '0;
      dispPtr_q  <= '0;
      cmplPtr_q  <= '0;
      freePtr_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i]  <= EMPTY;
        srcAddr_q[i] <= '0;
        srcSize_q[i] <= '0;
        desAddr_q[i] <= '0;
        desSize_q[i] <= '0;
        profile_q[i] <= '0;
      end
    end else begin
      allocPtr_q <= allocPtr_d;
      dispPtr_q  <= dispPtr_d;
      cmplPtr_q  <= cmplPtr_d;
      freePtr_q  <= freePtr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (status_q[i] == BUSY && profile_q[i] != PROFILE_MAX)
          profile_q[i] <= profile_q[i] + PROFILE_WIDTH'(1);
      end
      if (doAlloc) begin
        srcAddr_q[allocPtr_q] <= wr_src_addr;
        srcSize_q[allocPtr_q] <= wr_src_size;
        desAddr_q[allocPtr_q] <= wr_des_addr;
        desSize_q[allocPtr_q] <= wr_des_size;
        profile_q[allocPtr_q] <= '0;
        status_q[allocPtr_q]  <= PENDING;
      end
      if (doDisp) status_q[dispPtr_q] <= BUSY;
      if (doCmpl) status_q[cmplPtr_q] <= DONE;
      if (doFree) status_q[freePtr_q] <= EMPTY;
    end
  end

  assign disp_index    = dispPtr_q;
  assign disp_src_addr = srcAddr_q[dispPtr_q];
  assign disp_src_size = srcSize_q[dispPtr_q];
  assign disp_des_addr = desAddr_q[dispPtr_q];
  assign disp_des_size = desSize_q[dispPtr_q];

  assign rd_src_addr = srcAddr_q[rd_index];
  assign rd_src_size = srcSize_q[rd_index];
  assign rd_des_addr = desAddr_q[rd_index];
  assign rd_des_size = desSize_q[rd_index];
  assign rd_status   = status_q[rd_index];
  assign rd_profile  = profile_q[rd_index];

  assign occupancy = count_q;
  assign err       = err_q;

endmodule

// File: doc/slot_ring_table.md
SLOT_RING_TABLE -- requirements
Module: slot_ring_table

Interface
REQ-001 SHALL provide parameter INDEX_WIDTH, default 2, log2 slot count (DEPTH = 2^INDEX_WIDTH).
REQ-002 SHALL provide parameters SRC_ADDR_WIDTH 32, SRC_SIZE_WIDTH 26, DST_ADDR_WIDTH 32, DST_SIZE_WIDTH 26, PROFILE_WIDTH 32, each the stored field width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 wr_valid / wr_ready  in / out  1  allocate handshake; wr_src_addr, wr_src_size, wr_des_addr, wr_des_size in, field widths, descriptor.
REQ-007 disp_valid / disp_ready  out / in  1  dispatch handshake; disp_index out INDEX_WIDTH; disp_src_addr, disp_src_size, disp_des_addr, disp_des_size out, field widths.
REQ-008 cmpl  in  1  completion pulse for oldest BUSY slot.
REQ-009 free  in  1  release pulse for oldest DONE slot.
REQ-010 rd_index  in  INDEX_WIDTH; rd_src_addr, rd_src_size, rd_des_addr, rd_des_size, rd_status (2), rd_profile (PROFILE_WIDTH) out: combinational read of slot rd_index.
REQ-011 occupancy  out  INDEX_WIDTH+1  non-EMPTY slot count; err  out  1  one-cycle protocol-error pulse.

Function
REQ-012 Each slot SHALL hold a 2-bit status: EMPTY=0, PENDING=1, BUSY=2, DONE=3.
REQ-013 Four INDEX_WIDTH pointers (alloc, disp, cmpl, free) SHALL advance modulo DEPTH, wrapping from DEPTH-1 to 0; slots traverse EMPTY->PENDING->BUSY->DONE->EMPTY strictly in ring order.
REQ-014 wr_ready SHALL equal (occupancy < DEPTH), from registered state only; a free in the same cycle does not raise wr_ready.
REQ-015 wr_valid&&wr_ready SHALL write the four fields into slot alloc, set it PENDING, clear its profile to 0, advance alloc; visible on rd_* next cycle.
REQ-016 disp_valid SHALL be 1 iff slot disp is PENDING; disp_* SHALL show that slot's fields, disp_index = disp pointer; payload held stable while disp_valid&&!disp_ready.
REQ-017 disp_valid&&disp_ready SHALL set slot disp BUSY and advance disp.
REQ-018 cmpl with slot cmpl BUSY (at cycle start) SHALL set it DONE and advance cmpl; a slot dispatched in the same cycle is not completable until the next cycle.
REQ-019 free with slot free DONE SHALL set it EMPTY and advance free; its fields SHALL remain readable unchanged.
REQ-020 cmpl with no BUSY slot, or free with no DONE slot, SHALL be ignored (no state change) and pulse err for one cycle.
REQ-021 Each BUSY slot's profile SHALL increment by 1 per cycle, saturating at 2^PROFILE_WIDTH-1; frozen in PENDING, DONE, EMPTY.
REQ-022 Profile of a slot SHALL count cycles from the dispatch-handshake cycle's next edge through the cmpl-cycle edge inclusive (dispatch at cycle t, cmpl at cycle t+n -> profile n).
REQ-023 Allocate, dispatch, complete and free SHALL all be accepted in the same cycle when each is individually legal; occupancy SHALL update by (+alloc - free).
REQ-024 rd_* SHALL be purely combinational from rd_index and slot registers, zero latency.

Reset
REQ-025 reset low at a clock edge SHALL set all pointers 0, every status EMPTY, every profile 0, every field 0, occupancy 0, err 0; wr_ready=1, disp_valid=0 the cycle after.
REQ-026 Reset asserted mid-operation SHALL abandon all in-flight slots with no err pulse; handshakes on that edge are discarded.

Verification
REQ-027 Reset, then allocate src 0x1000/0x40 dst 0x2000/0x40 -> next cycle rd_index=0 gives those fields, rd_status=1, occupancy=1, disp_valid=1, disp_index=0.
REQ-028 DEPTH=4: four back-to-back allocates -> wr_ready=0, occupancy=4; fifth wr_valid ignored; free of DONE slot 0 -> wr_ready=1 next cycle, then allocate lands in slot 0 (wrap).
REQ-029 Dispatch at cycle 10, cmpl at cycle 15 -> rd_status=3, rd_profile=5, remains 5 for 20 idle cycles.
REQ-030 cmpl with zero BUSY slots, free with zero DONE slots -> err pulses one cycle each, statuses unchanged.
REQ-031 Same cycle: allocate slot 2, dispatch slot 1, cmpl slot 0 -> next cycle statuses 0:DONE 1:BUSY 2:PENDING, occupancy 3.
REQ-032 PROFILE_WIDTH=4, BUSY 20 cycles -> rd_profile=15 (saturated); reset low mid-BUSY -> all statuses EMPTY, occupancy 0, err stays 0.
